// File: rtl/typedefs.sv
// ---------------------------------------------------------------------------
// typedefs
//
// Shared constants and types for the CPU datapath and its output port.
//   BIT_SIZE         - width of a datapath word
//   TX_CLKS_PER_BIT  - default serial bit period, in clock cycles
//   tx_state_t       - frame state of the serial transmitter
//   cnt_width()      - register width needed to count 0..n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package typedefs;

    localparam int BIT_SIZE        = 8;
    localparam int TX_CLKS_PER_BIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
//
// Baud counter for the serial transmitter. Counts 0..CLKS_PER_BIT-1 while
// enabled and wraps; tick is high during the last cycle of each bit period,
// so logic sampling tick on the rising edge advances exactly once per bit.
//
// Ports:
//   clock    in   single clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   enable   in   count this cycle
//   clear    in   synchronous clear to 0 (wins over enable)
//   tick     out  terminal-count pulse (enable && count == CLKS_PER_BIT-1)
// ---------------------------------------------------------------------------
module bit_timer #(
    parameter int CLKS_PER_BIT = typedefs::TX_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic aresetn,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    import typedefs::*;

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // With CLKS_PER_BIT == 1 the counter is stuck at 0 == LAST, so every
    // enabled cycle is a terminal count.
    assign tick = enable && (count == LAST);

    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge; blocking writes here would create ordering races.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx
//
// Parallel-in, serial-out transmitter on the CPU output port. A word is
// captured on the edge where load && ready, then sent LSB first framed by
// one start bit (0) and one stop bit (1); each bit lasts CLKS_PER_BIT cycles.
//
// Ports:
//   clock    in   single clock, rising edge
//   aresetn  in   asynchronous active-low reset; aborts any frame
//   data     in   [BIT_SIZE] word to send, sampled only on the accepting edge
//   load     in   transmit request; ignored (not queued) while ready is low
//   ready    out  high in IDLE: a load will be accepted on the next edge
//   busy     out  !ready: a frame is in progress
//   txd      out  registered serial line, idles high
//   done     out  one-cycle pulse in the first IDLE cycle after the stop bit
// ---------------------------------------------------------------------------
module serial_tx #(
    parameter int BIT_SIZE     = typedefs::BIT_SIZE,
    parameter int CLKS_PER_BIT = typedefs::TX_CLKS_PER_BIT
) (
    input  logic                clock,
    input  logic                aresetn,
    input  logic [BIT_SIZE-1:0] data,
    input  logic                load,
    output logic                ready,
    output logic                busy,
    output logic                txd,
    output logic                done
);
    import typedefs::*;

    localparam int            BW       = cnt_width(BIT_SIZE);
    localparam logic [BW-1:0] LAST_BIT = BW'(BIT_SIZE - 1);

    tx_state_t           state;
    tx_state_t           next_state;
    logic [BIT_SIZE-1:0] shift_reg;
    logic [BIT_SIZE-1:0] shift_next;
    logic [BW-1:0]       bit_cnt;
    logic [BW-1:0]       bit_next;
    logic                txd_next;
    logic                done_next;
    logic                tick;
    logic                idle;
    logic                accept;

    assign idle   = (state == IDLE);
    assign accept = load && idle;

    // ready/busy decode the state register only, so they move on the
    // accepting edge and have no combinational path from load.
    assign ready = idle;
    assign busy  = !idle;

    // Held cleared while idle so every frame starts at a bit boundary on
    // the accepting edge.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .aresetn(aresetn),
        .enable (!idle),
        .clear  (idle),
        .tick   (tick)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (load)                          next_state = START;
            START:   if (tick)                          next_state = DATA;
            DATA:    if (tick && (bit_cnt == LAST_BIT)) next_state = STOP;
            STOP:    if (tick)                          next_state = IDLE;
            default:                                    next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default on the first lines;
    // a path that left one unassigned would infer a latch.
    always_comb begin
        shift_next = shift_reg;
        bit_next   = bit_cnt;
        txd_next   = 1'b1;
        done_next  = (state == STOP) && tick;

        if (accept) begin
            shift_next = data;
        end

        // The current bit always sits in shift_reg[0]. Shift only between
        // data bits; the last bit is left in place as the frame moves on.
        if ((state == DATA) && tick) begin
            if (bit_cnt == LAST_BIT) begin
                bit_next = '0;
            end else begin
                bit_next   = bit_cnt + 1'b1;
                shift_next = shift_reg >> 1;
            end
        end

        // txd is registered from the level of the state being entered, so
        // the line changes on the same edge as the state.
        unique case (next_state)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    // NOTE: the shift register is reset along with the control state so an
    // aborted frame leaves no trace of the captured word.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            txd       <= 1'b1;
            done      <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
            txd       <= txd_next;
            done      <= done_next;
        end
    end

endmodule
